// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - write-only SPI mode-0 slave feeding a five-register PWM control bank
//
// Parameters:
//   SYNC_STAGES  flops per input synchroniser (2..3)
//   MAX_ADDR     highest writable register address
// Ports:
//   clk, rst                   system clock, synchronous active-high reset
//   sclk, copi, ncs            asynchronous SPI inputs (mode 0, ncs active low)
//   en_reg_out_7_0   .. 0x00   output enables for uo_out[7:0]
//   en_reg_out_15_8  .. 0x01   output enables for uio_out[7:0]
//   en_reg_pwm_7_0   .. 0x02   PWM enables for uo_out[7:0]
//   en_reg_pwm_15_8  .. 0x03   PWM enables for uio_out[7:0]
//   pwm_duty_cycle   .. 0x04   duty cycle
//   wr_pulse                   one-cycle pulse on a register write
//   frame_err                  one-cycle pulse on a wrong-length frame

module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse,
  output logic       frame_err
);

  localparam logic [6:0] MAX_A     = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL  = 5'd16;
  localparam logic [4:0] CNT_OVER  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_hist;
  logic                   ncs_hist;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_rise;
  logic ncs_fall;

  // settle fills with ones after reset; its top bit marks the point where
  // the synchronised ncs and its history both hold real pin samples.
  logic [SYNC_STAGES:0] settle;
  logic                 armed;

  state_t      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_s;
      ncs_hist  <= ncs_s;
    end
  end

  // A frame already running when reset releases must not be picked up
  // part-way: frames are accepted only after ncs has genuinely been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && ncs_s) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_pulse        <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall && armed) begin
            state     <= ST_SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          // ncs rising takes priority: a coincident sclk edge is dropped.
          if (ncs_rise) begin
            state <= ST_COMMIT;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != CNT_OVER) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (bit_cnt != CNT_FULL) begin
            frame_err <= 1'b1;
          end else if (shift_reg[15] && (shift_reg[14:8] <= MAX_A)) begin
            // Addresses above 4 but within MAX_ADDR acknowledge with no storage.
            wr_pulse <= 1'b1;
            case (shift_reg[14:8])
              7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
              7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
              7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
              7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
              7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench for spi_reg_bank

module tb_spi_reg_bank;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_pulse;
  logic       frame_err;

  spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_pulse        (wr_pulse),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m[5];
  logic [7:0] obs[5];
  int         checks = 0;
  int         errors = 0;
  int         n_wr   = 0;
  int         n_err  = 0;
  bit         prev_wr  = 1'b0;
  bit         prev_err = 1'b0;

  always_comb begin
    obs[0] = en_reg_out_7_0;
    obs[1] = en_reg_out_15_8;
    obs[2] = en_reg_pwm_7_0;
    obs[3] = en_reg_pwm_15_8;
    obs[4] = pwm_duty_cycle;
  end

  // Scoreboard monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (wr_pulse && prev_wr) begin
      checks++; errors++;
      $display("FAIL wr_pulse_width high for 2+ cycles, required 1");
    end
    if (frame_err && prev_err) begin
      checks++; errors++;
      $display("FAIL frame_err_width high for 2+ cycles, required 1");
    end
    if ((wr_pulse && !prev_wr) || (frame_err && !prev_err)) begin
      if (wr_pulse)  n_wr++;
      if (frame_err) n_err++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse wr=%0b err=%0b, required no pulse", wr_pulse, frame_err);
      end else begin
        e = exp_q.pop_front();
        if (wr_pulse !== e.is_wr || frame_err !== !e.is_wr) begin
          errors++;
          $display("FAIL pulse_kind wr=%0b err=%0b, required wr=%0b err=%0b",
                   wr_pulse, frame_err, e.is_wr, !e.is_wr);
        end else if (e.is_wr && obs[e.addr] !== e.data) begin
          errors++;
          $display("FAIL commit_data reg%0d=%02h, required %02h", e.addr, obs[e.addr], e.data);
        end
      end
    end
    prev_wr  = wr_pulse;
    prev_err = frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, input int jit);
    copi = b;
    wait_clk(3 + $urandom_range(0, jit));
    sclk = 1'b1;
    wait_clk(3 + $urandom_range(0, jit));
    sclk = 1'b0;
  endtask

  // Sends one frame and records what the spec says it should cause.
  task automatic frame(input logic [31:0] val, input int nbits, input int jit);
    logic [15:0] w;
    exp_t        e;
    w = val[15:0];
    if (nbits != 16) begin
      e.is_wr = 1'b0; e.addr = 0; e.data = 8'h00;
      exp_q.push_back(e);
    end else if (w[15] && w[14:8] <= 7'd4) begin
      e.is_wr = 1'b1; e.addr = int'(w[14:8]); e.data = w[7:0];
      exp_q.push_back(e);
      m[e.addr] = e.data;
    end
    ncs = 1'b0;
    wait_clk(3 + $urandom_range(0, jit));
    for (int i = nbits - 1; i >= 0; i--) spi_bit(val[i], jit);
    wait_clk(3 + $urandom_range(0, jit));
    ncs = 1'b1;
    wait_clk(3 + $urandom_range(0, jit));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) wait_clk(1);
    wait_clk(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    for (int i = 0; i < 5; i++) begin
      m[i] = 8'h00;
      checks++;
      if (obs[i] !== 8'h00) begin
        errors++; $display("FAIL reset_reg%0d got %02h required 00", i, obs[i]);
      end
    end
    checks++;
    if (wr_pulse !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses wr=%0b err=%0b required 0 0", wr_pulse, frame_err);
    end
    wait_clk(4);
  endtask

  task automatic test_discard();
    int wr0, er0;
    wr0 = n_wr; er0 = n_err;
    frame(32'h0055, 16, 0);
    frame(32'h8A42, 16, 0);
    frame(32'h0ABC, 12, 0);
    frame(32'hF1234, 20, 0);
    drain();
    checks++;
    if (n_wr - wr0 != 0) begin
      errors++; $display("FAIL discard_wr got %0d pulses required 0", n_wr - wr0);
    end
    checks++;
    if (n_err - er0 != 2) begin
      errors++; $display("FAIL discard_err got %0d pulses required 2", n_err - er0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL discard_pending got %0d events left required 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs[i] !== 8'h00) begin
        errors++; $display("FAIL discard_reg%0d got %02h required 00", i, obs[i]);
      end
    end
  endtask

  task automatic test_basic_write();
    int wr0;
    wr0 = n_wr;
    frame(32'h80F0, 16, 0);
    drain();
    checks++;
    if (n_wr - wr0 != 1) begin
      errors++; $display("FAIL basic_wr got %0d pulses required 1", n_wr - wr0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs[i] !== m[i]) begin
        errors++; $display("FAIL basic_reg%0d got %02h required %02h", i, obs[i], m[i]);
      end
    end
  endtask

  task automatic test_each_addr();
    frame(32'h81CC, 16, 0);
    frame(32'h82FF, 16, 0);
    frame(32'h830F, 16, 0);
    frame(32'h8480, 16, 0);
    drain();
    checks++;
    if (pwm_duty_cycle !== 8'h80) begin
      errors++; $display("FAIL each_duty got %02h required 80", pwm_duty_cycle);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs[i] !== m[i]) begin
        errors++; $display("FAIL each_reg%0d got %02h required %02h", i, obs[i], m[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int wr0, er0;
    logic [15:0] v;
    v = 16'h81AA;
    ncs = 1'b0;
    wait_clk(4);
    for (int i = 15; i >= 8; i--) spi_bit(v[i], 0);
    rst = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    for (int i = 0; i < 5; i++) begin
      m[i] = 8'h00;
      checks++;
      if (obs[i] !== 8'h00) begin
        errors++; $display("FAIL midrst_reg%0d got %02h required 00", i, obs[i]);
      end
    end
    wr0 = n_wr; er0 = n_err;
    for (int i = 7; i >= 0; i--) spi_bit(v[i], 0);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(10);
    checks++;
    if (n_wr != wr0 || n_err != er0) begin
      errors++; $display("FAIL midrst_tail wr=%0d err=%0d pulses required 0 0", n_wr - wr0, n_err - er0);
    end
    frame(32'h81AA, 16, 0);
    drain();
    checks++;
    if (en_reg_out_15_8 !== 8'hAA) begin
      errors++; $display("FAIL midrst_refill got %02h required AA", en_reg_out_15_8);
    end
  endtask

  task automatic test_back_to_back(input int jit);
    int wr0;
    logic [7:0] d;
    wr0 = n_wr;
    for (int a = 0; a < 5; a++) begin
      d = 8'($urandom);
      frame({16'h0, 1'b1, 7'(a), d}, 16, jit);
    end
    drain();
    checks++;
    if (n_wr - wr0 != 5) begin
      errors++; $display("FAIL b2b_wr jit=%0d got %0d pulses required 5", jit, n_wr - wr0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs[i] !== m[i]) begin
        errors++; $display("FAIL b2b_reg%0d jit=%0d got %02h required %02h", i, jit, obs[i], m[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    test_reset();
    test_discard();
    test_basic_write();
    test_each_addr();
    test_reset_mid_frame();
    test_back_to_back(0);
    test_back_to_back(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_pending got %0d events left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
